// File: rtl/ads_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ads_emu_pkg
//  Description : Shared constants and types for the ADS converter emulator.
//  Revision    : 1.0  initial release
// ============================================================================
package ads_emu_pkg;

    // Default sample / configuration word width
    localparam int DEF_DATA_W = 16;

    // Opcode nibble that marks a configuration write on SDI
    localparam logic [3:0] CFG_WR_OP = 4'hE;

    // Conversion state machine
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2
    } state_e;

    // True when the received opcode nibble is a configuration write
    function automatic logic cfg_op_ok(input logic [3:0] op);
        return (op == CFG_WR_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ads_emu_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ads_emu_sync
//  Description : Multi-stage synchronizer for one asynchronous ADS pin, with
//                registered single-cycle rise / fall pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module ads_emu_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0   // idle level of the pin
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchronizer chain followed by a one-flop edge detector; pulses are
    // registered so every edge reaches the core SYNC_STAGES+1 cycles late.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/ads_emu.sv
`default_nettype none
// ============================================================================
//  Module      : ads_emu
//  Description : Converter-side responder of the dual-channel ADS serial ADC
//                link: CONVST -> timed BUSY, sample shift-out on SDOA/SDOB,
//                configuration capture from SDI.
//  Build macro : ADS_EMU_RAMP_EN - samples from an internal ramp (A=ramp,
//                B=~ramp) instead of the smp_a / smp_b ports.
//  Revision    : 1.0  initial release
// ============================================================================
module ads_emu
    import ads_emu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CONV_CYCLES = 150,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ADS_CLK,
    input  logic              ADS_CS_N,
    input  logic              ADS_CONVST,
    input  logic              ADS_SDI,
    input  logic [1:0]        ADS_M,
`ifndef ADS_EMU_RAMP_EN
    input  logic [DATA_W-1:0] smp_a,
    input  logic [DATA_W-1:0] smp_b,
`endif
    output logic              ADS_BUSY,
    output logic              ADS_SDOA,
    output logic              ADS_SDOB,
    output logic [DATA_W-1:0] cfg_word,
    output logic              cfg_valid,
    output logic              ovr_err
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam int BIT_W = $clog2(2*DATA_W + 1);
    localparam int RX_W  = $clog2(DATA_W + 2);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic w_clk_lvl,  w_clk_rise,  w_clk_fall;
    logic w_cs_lvl,   w_cs_rise,   w_cs_fall;
    logic w_conv_lvl, w_conv_rise, w_conv_fall;
    logic w_sdi_lvl,  w_sdi_rise,  w_sdi_fall;
    logic w_m0_lvl,   w_m0_rise,   w_m0_fall;
    logic w_unused;

    ads_emu_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d_i(ADS_CLK),
        .q_o(w_clk_lvl), .rise_o(w_clk_rise), .fall_o(w_clk_fall));

    ads_emu_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d_i(ADS_CS_N),
        .q_o(w_cs_lvl), .rise_o(w_cs_rise), .fall_o(w_cs_fall));

    ads_emu_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_conv (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d_i(ADS_CONVST),
        .q_o(w_conv_lvl), .rise_o(w_conv_rise), .fall_o(w_conv_fall));

    ads_emu_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d_i(ADS_SDI),
        .q_o(w_sdi_lvl), .rise_o(w_sdi_rise), .fall_o(w_sdi_fall));

    ads_emu_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_m0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d_i(ADS_M[0]),
        .q_o(w_m0_lvl), .rise_o(w_m0_rise), .fall_o(w_m0_fall));

    // Only levels or edges that the protocol needs are consumed; ADS_M[1]
    // has no function on this converter.
    assign w_unused = ^{w_clk_lvl, w_cs_lvl, w_conv_lvl, w_conv_fall,
                        w_sdi_rise, w_sdi_fall, w_m0_rise, w_m0_fall, ADS_M[1]};

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic               ovr_q, ovr_d;
    logic               w_latch;

    // State, conversion counter and overrun flag registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            conv_cnt_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic: CONVST starts a conversion unless one is running
    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        ovr_d      = ovr_q;
        w_latch    = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (w_conv_rise) begin
                    state_d    = CONV;
                    conv_cnt_d = CNT_W'(CONV_CYCLES - 1);
                end
            end
            CONV: begin
                if (w_conv_rise) begin
                    ovr_d = 1'b1;
                end
                if (conv_cnt_q == '0) begin
                    w_latch = 1'b1;
                    state_d = READY;
                end else begin
                    conv_cnt_d = conv_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample source and latched words
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_src_a, w_src_b;
    logic [DATA_W-1:0] word_a_q, word_b_q;

`ifdef ADS_EMU_RAMP_EN
    logic [DATA_W-1:0] ramp_q;

    // Ramp advances once per conversion end, after its value is latched
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ramp_q <= '0;
        end else if (w_latch) begin
            ramp_q <= ramp_q + 1'b1;
        end
    end

    assign w_src_a = ramp_q;
    assign w_src_b = ~ramp_q;
`else
    assign w_src_a = smp_a;
    assign w_src_b = smp_b;
`endif

    // Capture the words at conversion end; they persist for repeated reads
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            word_a_q <= '0;
            word_b_q <= '0;
        end else if (w_latch) begin
            word_a_q <= w_src_a;
            word_b_q <= w_src_b;
        end
    end

    // ------------------------------------------------------------------
    // Serial frame: sample shift-out and configuration capture
    // ------------------------------------------------------------------
    logic                active_q,    active_d;
    logic [BIT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [RX_W-1:0]     rx_cnt_q,    rx_cnt_d;
    logic [DATA_W-1:0]   sdi_sr_q,    sdi_sr_d;
    logic [DATA_W-1:0]   cfg_word_q,  cfg_word_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                sdoa_q,      sdoa_d;
    logic                sdob_q,      sdob_d;
    logic [DATA_W-1:0]   w_sh_a, w_sh_b;
    logic [2*DATA_W-1:0] w_sh_ab;

    // Frame registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            active_q    <= 1'b0;
            bit_cnt_q   <= '0;
            rx_cnt_q    <= '0;
            sdi_sr_q    <= '0;
            cfg_word_q  <= '0;
            cfg_valid_q <= 1'b0;
            sdoa_q      <= 1'b0;
            sdob_q      <= 1'b0;
        end else begin
            active_q    <= active_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            sdi_sr_q    <= sdi_sr_d;
            cfg_word_q  <= cfg_word_d;
            cfg_valid_q <= cfg_valid_d;
            sdoa_q      <= sdoa_d;
            sdob_q      <= sdob_d;
        end
    end

    // Frame control; the output bit is picked by shifting the latched word
    // left by the bit count, so counts past the frame length yield 0.
    always_comb begin
        active_d    = active_q;
        bit_cnt_d   = bit_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        sdi_sr_d    = sdi_sr_q;
        cfg_word_d  = cfg_word_q;
        cfg_valid_d = 1'b0;

        if (w_cs_fall) begin
            active_d  = 1'b1;
            bit_cnt_d = '0;
            rx_cnt_d  = '0;
        end else if (w_cs_rise) begin
            active_d  = 1'b0;
            bit_cnt_d = '0;
            if (active_q && (rx_cnt_q == RX_W'(DATA_W)) &&
                cfg_op_ok(sdi_sr_q[DATA_W-1 -: 4])) begin
                cfg_word_d                = '0;
                cfg_word_d[DATA_W-5:0]    = sdi_sr_q[DATA_W-5:0];
                cfg_valid_d               = 1'b1;
            end
        end else if (active_q) begin
            if (w_clk_fall && (bit_cnt_q != BIT_W'(2*DATA_W))) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (w_clk_rise) begin
                sdi_sr_d = {sdi_sr_q[DATA_W-2:0], w_sdi_lvl};
                if (rx_cnt_q != RX_W'(DATA_W + 1)) begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        end

        w_sh_a  = word_a_q << bit_cnt_d;
        w_sh_b  = word_b_q << bit_cnt_d;
        w_sh_ab = {word_a_q, word_b_q} << bit_cnt_d;

        if (!active_d) begin
            sdoa_d = 1'b0;
            sdob_d = 1'b0;
        end else if (w_m0_lvl) begin
            sdoa_d = w_sh_ab[2*DATA_W-1];
            sdob_d = 1'b0;
        end else begin
            sdoa_d = w_sh_a[DATA_W-1];
            sdob_d = w_sh_b[DATA_W-1];
        end
    end

    assign ADS_BUSY  = (state_q == CONV);
    assign ADS_SDOA  = sdoa_q;
    assign ADS_SDOB  = sdob_q;
    assign cfg_word  = cfg_word_q;
    assign cfg_valid = cfg_valid_q;
    assign ovr_err   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_ads_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ads_emu
//  Description : Self-checking bench for ads_emu (table of frame vectors plus
//                directed conversion / overrun / reset sequences).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ads_emu;

    localparam int HALF = 5;   // ADS_CLK half period in sys_clk cycles

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        ADS_CLK    = 1'b0;
    logic        ADS_CS_N   = 1'b1;
    logic        ADS_CONVST = 1'b0;
    logic        ADS_SDI    = 1'b0;
    logic [1:0]  ADS_M      = 2'b00;
    logic [15:0] smp_a      = 16'h0000;
    logic [15:0] smp_b      = 16'h0000;
    logic        ADS_BUSY, ADS_SDOA, ADS_SDOB, cfg_valid, ovr_err;
    logic [15:0] cfg_word;

    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;

    ads_emu dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .ADS_CLK    (ADS_CLK),
        .ADS_CS_N   (ADS_CS_N),
        .ADS_CONVST (ADS_CONVST),
        .ADS_SDI    (ADS_SDI),
        .ADS_M      (ADS_M),
`ifndef ADS_EMU_RAMP_EN
        .smp_a      (smp_a),
        .smp_b      (smp_b),
`endif
        .ADS_BUSY   (ADS_BUSY),
        .ADS_SDOA   (ADS_SDOA),
        .ADS_SDOB   (ADS_SDOB),
        .cfg_word   (cfg_word),
        .cfg_valid  (cfg_valid),
        .ovr_err    (ovr_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Count every cycle cfg_valid is high
    always @(negedge sys_clk) begin
        if (cfg_valid) n_valid++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        m0;
        int          nclk;
        logic [15:0] sdi;
        logic [33:0] exp_a;
        logic [33:0] exp_b;
        logic [1:0]  exp_s4;
        int          exp_pulses;
        logic [15:0] exp_cfg;
    } vec_t;

    vec_t vecs [6];

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pulse CONVST; measure BUSY latency and width, optionally raise a second
    // CONVST second_at cycles into BUSY
    task automatic conversion(input int second_at, output int lat, output int width);
        ADS_CONVST = 1'b1;
        lat = 0;
        while (!ADS_BUSY && lat < 20) begin
            tick(1);
            lat++;
        end
        width = 0;
        while (ADS_BUSY && width < 400) begin
            tick(1);
            width++;
            if (width == 8) ADS_CONVST = 1'b0;
            if (second_at != 0 && width == second_at) ADS_CONVST = 1'b1;
            if (second_at != 0 && width == second_at + 8) ADS_CONVST = 1'b0;
        end
        ADS_CONVST = 1'b0;
        tick(10);
    endtask

    // One serial frame of nclk clocks; returns the bits seen (MSB first),
    // SDO 3 and 4 cycles after CS_N fall, and cfg_valid latency after CS_N rise
    task automatic frame(input logic m0, input int nclk, input logic [15:0] sdi,
                         output logic [33:0] sa, output logic [33:0] sb,
                         output logic [1:0] s3, output logic [1:0] s4, output int clat);
        logic [15:0] sh;
        sh = sdi;
        ADS_M = {1'b0, m0};
        tick(HALF);
        ADS_CS_N = 1'b0;
        tick(3);
        s3 = {ADS_SDOA, ADS_SDOB};
        tick(1);
        s4 = {ADS_SDOA, ADS_SDOB};
        tick(2);
        sa = '0;
        sb = '0;
        for (int i = 0; i < nclk; i++) begin
            ADS_SDI = sh[15];
            sh = sh << 1;
            sa = {sa[32:0], ADS_SDOA};
            sb = {sb[32:0], ADS_SDOB};
            ADS_CLK = 1'b1;
            tick(HALF);
            ADS_CLK = 1'b0;
            tick(HALF);
        end
        ADS_SDI  = 1'b0;
        ADS_CS_N = 1'b1;
        clat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (cfg_valid && clat == 0) clat = k;
        end
        tick(HALF);
    endtask

    initial begin
        logic [15:0] wa, wb;
        logic [33:0] sa, sb;
        logic [1:0]  s3, s4;
        int          lat, width, clat, nv0;

        // ---------------- reset values ----------------
        tick(3);
        check("rst_busy",      64'(ADS_BUSY),  64'd0);
        check("rst_sdoa",      64'(ADS_SDOA),  64'd0);
        check("rst_sdob",      64'(ADS_SDOB),  64'd0);
        check("rst_cfg_word",  64'(cfg_word),  64'd0);
        check("rst_cfg_valid", 64'(cfg_valid), 64'd0);
        check("rst_ovr_err",   64'(ovr_err),   64'd0);
        sys_rst_n = 1'b1;
        tick(5);

        // ---------------- first conversion ----------------
`ifdef ADS_EMU_RAMP_EN
        wa = 16'h0000; wb = 16'hFFFF;
`else
        smp_a = 16'hA5C3; smp_b = 16'h3C5A;
        wa = 16'hA5C3; wb = 16'h3C5A;
`endif
        conversion(0, lat, width);
        check("conv1_latency", 64'(lat),     64'd4);
        check("conv1_width",   64'(width),   64'd150);
        check("conv1_ovr",     64'(ovr_err), 64'd0);

        // ---------------- frame vector table ----------------
        vecs[0] = '{1'b0, 16, 16'hE123, {18'b0, wa}, {18'b0, wb}, {wa[15], wb[15]}, 1, 16'h0123};
        vecs[1] = '{1'b1, 34, 16'h0000, {wa, wb, 2'b00}, 34'd0, {wa[15], 1'b0}, 0, 16'h0123};
        vecs[2] = '{1'b0, 16, 16'h7123, {18'b0, wa}, {18'b0, wb}, {wa[15], wb[15]}, 0, 16'h0123};
        vecs[3] = '{1'b0, 15, 16'hE456, {19'b0, wa[15:1]}, {19'b0, wb[15:1]}, {wa[15], wb[15]}, 0, 16'h0123};
        vecs[4] = '{1'b0, 18, 16'hE456, {16'b0, wa, 2'b00}, {16'b0, wb, 2'b00}, {wa[15], wb[15]}, 0, 16'h0123};
        vecs[5] = '{1'b0, 16, 16'hEABC, {18'b0, wa}, {18'b0, wb}, {wa[15], wb[15]}, 1, 16'h0ABC};

        for (int v = 0; v < 6; v++) begin
            nv0 = n_valid;
            frame(vecs[v].m0, vecs[v].nclk, vecs[v].sdi, sa, sb, s3, s4, clat);
            check($sformatf("v%0d_sdoa_bits", v), 64'(sa), 64'(vecs[v].exp_a));
            check($sformatf("v%0d_sdob_bits", v), 64'(sb), 64'(vecs[v].exp_b));
            check($sformatf("v%0d_sdo_early", v), 64'(s3), 64'd0);
            check($sformatf("v%0d_sdo_msb_lat", v), 64'(s4), 64'(vecs[v].exp_s4));
            check($sformatf("v%0d_cfg_pulses", v), 64'(n_valid - nv0), 64'(vecs[v].exp_pulses));
            check($sformatf("v%0d_cfg_lat", v), 64'(clat), (vecs[v].exp_pulses != 0) ? 64'd4 : 64'd0);
            check($sformatf("v%0d_cfg_word", v), 64'(cfg_word), 64'(vecs[v].exp_cfg));
        end

        // ---------------- second conversion ----------------
`ifdef ADS_EMU_RAMP_EN
        wa = 16'h0001; wb = 16'hFFFE;
`else
        smp_a = 16'h1234; smp_b = 16'hFEDC;
        wa = 16'h1234; wb = 16'hFEDC;
`endif
        conversion(0, lat, width);
        check("conv2_width", 64'(width), 64'd150);
        frame(1'b0, 16, 16'h0000, sa, sb, s3, s4, clat);
        check("conv2_sdoa", 64'(sa), 64'({18'b0, wa}));
        check("conv2_sdob", 64'(sb), 64'({18'b0, wb}));

        // ---------------- overrun ----------------
        conversion(20, lat, width);
        check("ovr_width",   64'(width),   64'd150);
        check("ovr_flag",    64'(ovr_err), 64'd1);
        tick(20);
        check("ovr_no_restart", 64'(ADS_BUSY), 64'd0);
        check("ovr_sticky",     64'(ovr_err),  64'd1);

        // ---------------- reset mid-conversion and mid-frame ----------------
        ADS_CONVST = 1'b1;
        tick(6);
        ADS_CONVST = 1'b0;
        ADS_M      = 2'b00;
        ADS_CS_N   = 1'b0;
        tick(6);
        check("pre_rst_busy", 64'(ADS_BUSY), 64'd1);
        check("pre_rst_sdob", 64'(ADS_SDOB), 64'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      64'(ADS_BUSY),  64'd0);
        check("mid_rst_sdoa",      64'(ADS_SDOA),  64'd0);
        check("mid_rst_sdob",      64'(ADS_SDOB),  64'd0);
        check("mid_rst_cfg_word",  64'(cfg_word),  64'd0);
        check("mid_rst_cfg_valid", 64'(cfg_valid), 64'd0);
        check("mid_rst_ovr_err",   64'(ovr_err),   64'd0);
        ADS_CS_N = 1'b1;
        tick(2);
        sys_rst_n = 1'b1;
        tick(5);

        // Latched words cleared by reset
        frame(1'b0, 16, 16'h0000, sa, sb, s3, s4, clat);
        check("post_rst_sdoa", 64'(sa), 64'd0);
        check("post_rst_sdob", 64'(sb), 64'd0);

        // Clean conversion after reset
`ifdef ADS_EMU_RAMP_EN
        wa = 16'h0000; wb = 16'hFFFF;
`else
        wa = 16'h1234; wb = 16'hFEDC;
`endif
        conversion(0, lat, width);
        check("post_rst_latency", 64'(lat),     64'd4);
        check("post_rst_width",   64'(width),   64'd150);
        check("post_rst_ovr",     64'(ovr_err), 64'd0);
        frame(1'b0, 16, 16'h0000, sa, sb, s3, s4, clat);
        check("post_rst_conv_sdoa", 64'(sa), 64'({18'b0, wa}));
        check("post_rst_conv_sdob", 64'(sb), 64'({18'b0, wb}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
